// File: rtl/push_pwm_capture.sv
// Purpose : measure period and high time of an asynchronous PWM input in clk cycles.
// Latency : a pwm_in edge reaches the measurement registers a few clk cycles later (2 sync + detect + register).
// Backpressure: none; valid is a one-cycle strobe and the outputs hold until the next strobe.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   pwm_in     external PWM wave, asynchronous to clk
//   period     clk cycles between the last two synchronized rising edges
//   high_time  clk cycles from that rising edge to the following falling edge
//   valid      one-cycle strobe: period/high_time just updated
//   timeout    sticky: the wave stalled for TIMEOUT cycles; cleared by the next valid
//   busy       high while a measurement is in progress (HIGH or LOW state)
//
// TIMEOUT must be below 2**CNT_W so the counter can hold it.

module push_pwm_capture #(
  parameter int unsigned TIMEOUT = 1_000_000,
  parameter int unsigned CNT_W   = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // synchronizer and edge-detect delay
  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic w_rise;
  logic w_fall;

  // FSM state and datapath registers
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_time;
  logic             r_valid;
  logic             r_timeout;
  logic             r_busy;

  // next-state values
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_hi_cnt_nxt;
  logic [CNT_W-1:0] w_period_nxt;
  logic [CNT_W-1:0] w_high_time_nxt;
  logic             w_valid_nxt;
  logic             w_timeout_nxt;

  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_tmo_hit;

  // Two flops resolve metastability; s3 is the one-cycle delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= pwm_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;

  // A fall detected exactly at cnt == TIMEOUT pushes cnt one past the limit;
  // saturate so a TIMEOUT at the very top of the range cannot wrap to zero.
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : (r_cnt + CNT_ONE);
  // >= rather than == also catches the TIMEOUT+1 case reached via a late fall.
  assign w_tmo_hit = (r_cnt >= TMO_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_hi_cnt    <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hi_cnt    <= w_hi_cnt_nxt;
      r_period    <= w_period_nxt;
      r_high_time <= w_high_time_nxt;
      r_valid     <= w_valid_nxt;
      r_timeout   <= w_timeout_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hi_cnt_nxt    = r_hi_cnt;
    w_period_nxt    = r_period;
    w_high_time_nxt = r_high_time;
    w_valid_nxt     = 1'b0;
    w_timeout_nxt   = r_timeout;

    unique case (r_state)
      ST_IDLE: begin
        // Counting starts at 1 on the rise so that the next rise, P cycles later, reads P.
        // The first rise only arms the measurement; no valid until a full period is seen.
        w_cnt_nxt = '0;
        if (w_rise) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = CNT_ONE;
        end
      end

      ST_HIGH: begin
        w_cnt_nxt = w_cnt_inc;
        // The edge has priority over the stall check in the same cycle.
        if (w_fall) begin
          w_hi_cnt_nxt = r_cnt;
          w_state_nxt  = ST_LOW;
        end else if (w_tmo_hit) begin
          w_timeout_nxt = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_IDLE;
        end
      end

      ST_LOW: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_rise) begin
          w_period_nxt    = r_cnt;
          w_high_time_nxt = r_hi_cnt;
          w_valid_nxt     = 1'b1;
          w_timeout_nxt   = 1'b0;
          w_cnt_nxt       = CNT_ONE;
          w_state_nxt     = ST_HIGH;
        end else if (w_tmo_hit) begin
          w_timeout_nxt = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign period    = r_period;
  assign high_time = r_high_time;
  assign valid     = r_valid;
  assign timeout   = r_timeout;
  assign busy      = r_busy;

endmodule

// File: tb/tb_push_pwm_capture.sv
module tb_push_pwm_capture;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  logic pwm_a;
  logic pwm_b;

  logic [19:0] period_a;
  logic [19:0] high_a;
  logic        valid_a;
  logic        timeout_a;
  logic        busy_a;

  logic [19:0] period_b;
  logic [19:0] high_b;
  logic        valid_b;
  logic        timeout_b;
  logic        busy_b;

  int nchk = 0;
  int nerr = 0;

  // captured valid strobes: period, high_time, timeout at the strobe
  logic [19:0] cap_a_per[$];
  logic [19:0] cap_a_hi[$];
  logic        cap_a_to[$];
  logic [19:0] cap_b_per[$];
  logic [19:0] cap_b_hi[$];
  logic        cap_b_to[$];

  always #5 clk = ~clk;

  push_pwm_capture u_dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .pwm_in    (pwm_a),
    .period    (period_a),
    .high_time (high_a),
    .valid     (valid_a),
    .timeout   (timeout_a),
    .busy      (busy_a)
  );

  push_pwm_capture #(.TIMEOUT(100), .CNT_W(20)) u_dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .pwm_in    (pwm_b),
    .period    (period_b),
    .high_time (high_b),
    .valid     (valid_b),
    .timeout   (timeout_b),
    .busy      (busy_b)
  );

  always @(posedge clk) begin
    #1;
    if (valid_a) begin
      cap_a_per.push_back(period_a);
      cap_a_hi.push_back(high_a);
      cap_a_to.push_back(timeout_a);
    end
    if (valid_b) begin
      cap_b_per.push_back(period_b);
      cap_b_hi.push_back(high_b);
      cap_b_to.push_back(timeout_b);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each period starts with a rise; rises are exactly per cycles apart.
  task automatic wave_a(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_a = 1'b1;
      repeat (hi) @(negedge clk);
      pwm_a = 1'b0;
      repeat (per - hi) @(negedge clk);
    end
  endtask

  task automatic wave_b(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_b = 1'b1;
      repeat (hi) @(negedge clk);
      pwm_b = 1'b0;
      repeat (per - hi) @(negedge clk);
    end
  endtask

  // Check the strobes captured since base: first one (p0,h0), the rest (p,h), timeout 0.
  task automatic chk_caps(input bit sel_b, input string tag, input int base, input int n_exp,
                          input int p0, input int h0, input int p, input int h);
    int          n_got;
    logic [19:0] cp;
    logic [19:0] ch;
    logic        ct;
    n_got = sel_b ? (cap_b_per.size() - base) : (cap_a_per.size() - base);
    chk($sformatf("%s_count", tag), 32'(n_got), 32'(n_exp));
    for (int i = 0; i < n_exp && i < n_got; i++) begin
      if (sel_b) begin
        cp = cap_b_per[base + i];
        ch = cap_b_hi[base + i];
        ct = cap_b_to[base + i];
      end else begin
        cp = cap_a_per[base + i];
        ch = cap_a_hi[base + i];
        ct = cap_a_to[base + i];
      end
      chk($sformatf("%s_period%0d", tag, i), 32'(cp), 32'((i == 0) ? p0 : p));
      chk($sformatf("%s_high%0d", tag, i), 32'(ch), 32'((i == 0) ? h0 : h));
      chk($sformatf("%s_tmo%0d", tag, i), 32'(ct), 32'd0);
    end
  endtask

  int base;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    pwm_a = 1'b0;
    pwm_b = 1'b0;
    idle(3);

    // reset state
    chk("rst_a_period",  32'(period_a),  32'd0);
    chk("rst_a_high",    32'(high_a),    32'd0);
    chk("rst_a_valid",   32'(valid_a),   32'd0);
    chk("rst_a_timeout", 32'(timeout_a), 32'd0);
    chk("rst_a_busy",    32'(busy_a),    32'd0);
    chk("rst_b_period",  32'(period_b),  32'd0);
    chk("rst_b_high",    32'(high_b),    32'd0);
    chk("rst_b_valid",   32'(valid_b),   32'd0);
    chk("rst_b_timeout", 32'(timeout_b), 32'd0);
    chk("rst_b_busy",    32'(busy_b),    32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    idle(2);

    // 5 periods of 6251/3125: five rises give four strobes
    base = cap_a_per.size();
    wave_a(6251, 3125, 5);
    chk_caps(1'b0, "sq6251", base, 4, 6251, 3125, 6251, 3125);

    // switch to 1000 on the fly: first strobe still spans the last 6251 period
    base = cap_a_per.size();
    wave_a(1000, 500, 4);
    chk_caps(1'b0, "chg1000", base, 4, 6251, 3125, 1000, 500);

    // narrow high pulse, then near-full duty
    base = cap_a_per.size();
    wave_a(20, 1, 4);
    chk_caps(1'b0, "p20h1", base, 4, 1000, 500, 20, 1);
    base = cap_a_per.size();
    wave_a(20, 19, 4);
    chk_caps(1'b0, "p20h19", base, 4, 20, 1, 20, 19);

    // reset in the middle of the LOW phase
    idle(10);
    chk("midlow_busy", 32'(busy_a), 32'd1);
    rst_a = 1'b1;
    @(negedge clk);
    chk("midrst_period",  32'(period_a),  32'd0);
    chk("midrst_high",    32'(high_a),    32'd0);
    chk("midrst_valid",   32'(valid_a),   32'd0);
    chk("midrst_timeout", 32'(timeout_a), 32'd0);
    chk("midrst_busy",    32'(busy_a),    32'd0);
    rst_a = 1'b0;
    base = cap_a_per.size();
    wave_a(30, 15, 3);
    idle(10);
    chk_caps(1'b0, "post_rst", base, 2, 30, 15, 30, 15);

    // TIMEOUT=100: run a wave, then hold high (the held level is one more rise)
    base = cap_b_per.size();
    wave_b(20, 10, 3);
    pwm_b = 1'b1;
    idle(102);
    chk("stall_hi_cnt100_tmo",  32'(timeout_b), 32'd0);
    chk("stall_hi_cnt100_busy", 32'(busy_b),    32'd1);
    idle(1);
    chk("stall_hi_tmo",    32'(timeout_b), 32'd1);
    chk("stall_hi_busy",   32'(busy_b),    32'd0);
    chk("stall_hi_period", 32'(period_b),  32'd20);
    chk("stall_hi_high",   32'(high_b),    32'd10);
    chk_caps(1'b1, "b_p20", base, 3, 20, 10, 20, 10);

    // fall while idle is ignored; restart clears timeout on the next strobe; then stall low
    pwm_b = 1'b0;
    idle(20);
    chk("idle_fall_busy", 32'(busy_b),    32'd0);
    chk("idle_fall_tmo",  32'(timeout_b), 32'd1);
    base = cap_b_per.size();
    wave_b(20, 10, 2);
    idle(150);
    chk_caps(1'b1, "restart", base, 1, 20, 10, 20, 10);
    chk("stall_lo_tmo",    32'(timeout_b), 32'd1);
    chk("stall_lo_busy",   32'(busy_b),    32'd0);
    chk("stall_lo_period", 32'(period_b),  32'd20);

    // rise exactly at cnt == TIMEOUT wins; a 101-cycle low gap times out
    base = cap_b_per.size();
    wave_b(100, 50, 2);
    idle(10);
    chk_caps(1'b1, "edge_at_tmo", base, 1, 100, 50, 100, 50);
    chk("gap101_tmo",    32'(timeout_b), 32'd1);
    chk("gap101_busy",   32'(busy_b),    32'd0);
    chk("gap101_period", 32'(period_b),  32'd100);
    chk("gap101_high",   32'(high_b),    32'd50);

    // input already high when reset releases: starts a measurement, no strobe
    pwm_b = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    chk("rst_hi_period", 32'(period_b), 32'd0);
    chk("rst_hi_busy",   32'(busy_b),   32'd0);
    rst_b = 1'b0;
    base = cap_b_per.size();
    idle(4);
    chk("rel_hi_busy",   32'(busy_b), 32'd1);
    chk("rel_hi_nvalid", 32'(cap_b_per.size() - base), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
